// File: rtl/ex_mem_pkg.sv
// Shared widths, control values and stall-bit indices for the EX/MEM pipeline register.
package ex_mem_pkg;

    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;
    localparam int StallBus     = 6;
    localparam int CntBus       = 2;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    typedef struct packed {
        logic [RegAddrBus-1:0] waddr;
        logic                  we;
        logic [RegBus-1:0]     wdata;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
        logic                  whilo;
    } mem_req_t;

    localparam mem_req_t MemReqIdle = '{
        waddr: '0, we: WriteDisable, wdata: ZeroWord,
        hi: ZeroWord, lo: ZeroWord, whilo: WriteDisable
    };

endpackage

// File: rtl/ex_mem.sv
// EX->MEM pipeline register with flush/bubble/hold/advance control.
// EX_MEM_MADD_EN: keep the multiply-accumulate {hi,lo}/count state; otherwise it reads as 0.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RegAddrBus-1:0]   ex_waddr_reg,
    input  logic                    ex_we_reg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic                    ex_whilo,
    input  logic [StallBus-1:0]     stall,
    input  logic                    flush,
    input  logic [DoubleRegBus-1:0] hilo_temp_i,
    input  logic [CntBus-1:0]       cnt_i,
    output logic [RegAddrBus-1:0]   mem_waddr_reg,
    output logic                    mem_we_reg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic                    mem_whilo,
    output logic [DoubleRegBus-1:0] hilo_temp_o,
    output logic [CntBus-1:0]       cnt_o
);

    mem_req_t ex_req;
    mem_req_t mem_q;
    logic     bubble;
    logic     advance;

    assign ex_req = '{
        waddr: ex_waddr_reg, we: ex_we_reg, wdata: ex_wdata,
        hi: ex_hi, lo: ex_lo, whilo: ex_whilo
    };

    // EX stopped while MEM runs: a bubble goes down the pipe. The illegal
    // EX-running/MEM-stopped combination falls into advance.
    assign bubble  = (stall[STALL_EX] == Stop) && (stall[STALL_MEM] == NoStop);
    assign advance = (stall[STALL_EX] == NoStop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= MemReqIdle;
        end else if (flush) begin
            mem_q <= MemReqIdle;
        end else if (bubble) begin
            mem_q <= MemReqIdle;
        end else if (advance) begin
            mem_q <= ex_req;
        end
    end

    assign mem_waddr_reg = mem_q.waddr;
    assign mem_we_reg    = mem_q.we;
    assign mem_wdata     = mem_q.wdata;
    assign mem_hi        = mem_q.hi;
    assign mem_lo        = mem_q.lo;
    assign mem_whilo     = mem_q.whilo;

`ifdef EX_MEM_MADD_EN
    logic [DoubleRegBus-1:0] hilo_temp_q;
    logic [CntBus-1:0]       cnt_q;

    // The accumulate state must keep moving through bubbles, so it is
    // loaded on bubble and cleared once the instruction advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else if (flush) begin
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end else if (bubble) begin
            hilo_temp_q <= hilo_temp_i;
            cnt_q       <= cnt_i;
        end else if (advance) begin
            hilo_temp_q <= '0;
            cnt_q       <= '0;
        end
    end

    assign hilo_temp_o = hilo_temp_q;
    assign cnt_o       = cnt_q;
`else
    logic unused_madd;
    assign unused_madd = ^{hilo_temp_i, cnt_i};
    assign hilo_temp_o = '0;
    assign cnt_o       = '0;
`endif

    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    illegal_stall_a: assert property (@(posedge clk) disable iff (!rst)
        !((stall[STALL_EX] == NoStop) && (stall[STALL_MEM] == Stop)));

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have inputs ex_waddr_reg 5 bits, ex_we_reg 1 bit and ex_wdata 32 bits: the GPR write request from EX.
REQ-004 SHALL have inputs ex_hi 32 bits, ex_lo 32 bits and ex_whilo 1 bit: the HI/LO write request from EX.
REQ-005 SHALL have input stall, 6 bits, from ctrl; bit 3 means EX is stalled, bit 4 means MEM is stalled.
REQ-006 SHALL have input flush, 1 bit: a synchronous pipeline flush.
REQ-007 SHALL have inputs hilo_temp_i 64 bits and cnt_i 2 bits: the multiply-accumulate partial state from EX.
REQ-008 SHALL have outputs mem_waddr_reg 5 bits, mem_we_reg 1 bit and mem_wdata 32 bits: registered GPR request to MEM.
REQ-009 SHALL have outputs mem_hi 32 bits, mem_lo 32 bits and mem_whilo 1 bit: registered HI/LO request to MEM.
REQ-010 SHALL have outputs hilo_temp_o 64 bits and cnt_o 2 bits: the registered accumulate state, fed back to EX.

Function
REQ-011 SHALL evaluate the following rules in priority order on each rising clk edge while rst is high: flush, bubble, hold, advance.
REQ-012 Flush (flush=1): all outputs SHALL go to 0, including hilo_temp_o and cnt_o, regardless of stall.
REQ-013 Bubble (stall[3]=1, stall[4]=0): the outputs listed below SHALL take these values.
- mem_we_reg=0, mem_whilo=0, mem_waddr_reg=0, mem_wdata=0, mem_hi=0, mem_lo=0.
- hilo_temp_o<=hilo_temp_i and cnt_o<=cnt_i, so the multi-cycle accumulate keeps progressing.
REQ-014 Hold (stall[3]=1, stall[4]=1): every output register SHALL keep its value.
REQ-015 Advance (stall[3]=0): each mem_* output SHALL take its ex_* input, hilo_temp_o SHALL go to 0 and cnt_o SHALL go to 0.
REQ-016 The stall combination stall[3]=0 with stall[4]=1 is illegal; it SHALL be treated as advance and SHALL fire a simulation-only assertion.
REQ-017 Latency SHALL be exactly one cycle from the ex_* inputs to the mem_* outputs; there SHALL be no combinational path from input to output.
REQ-018 Data SHALL pass through unmodified; there is no arithmetic and no width change; hilo_temp is carried as {hi,lo}.
REQ-019 A bubble SHALL never assert mem_we_reg or mem_whilo, whatever the ex_* inputs hold.

Reset
REQ-020 Asserting rst low SHALL clear every output to 0 immediately, independent of clk, including mid-stall and mid-accumulate.
REQ-021 After rst deasserts, the first rising edge SHALL apply the REQ-011 rules normally; there is no warm-up cycle.

Configuration
REQ-022 Macro EX_MEM_MADD_EN defined: hilo_temp and cnt registers SHALL be implemented as described in REQ-012 to REQ-015.
REQ-023 Macro EX_MEM_MADD_EN undefined: hilo_temp_o and cnt_o SHALL be constant 0, and hilo_temp_i and cnt_i SHALL be ignored.
- No flops are inferred for them.
- All other behaviour is identical.

Structure
REQ-024 Bus widths and control values SHALL come from the shared defines header; none are redefined locally.
- Widths: RegBus, RegAddrBus, DoubleRegBus.
- Control values: WriteEnable/WriteDisable, Stop/NoStop, ZeroWord.
REQ-025 The shared header SHALL define the stall bit indices STALL_EX=3 and STALL_MEM=4; the block SHALL use them instead of literals.
REQ-026 The block SHALL be a single module with no sub-modules; the only inferred sequential logic is the output registers.

Verification
REQ-027 Advance: ex_waddr_reg=5'd8, ex_we_reg=1, ex_wdata=32'h1234_5678 with stall=0 -> after one edge, mem_waddr_reg=8, mem_we_reg=1, mem_wdata=32'h1234_5678.
REQ-028 Bubble: stall=6'b001111 with ex_we_reg=1, ex_whilo=1 and cnt_i=2'b01 -> after the edge, mem_we_reg=0, mem_whilo=0, mem_wdata=0, and cnt_o=1 (with the macro).
REQ-029 Hold: load mem_wdata=32'hDEAD_BEEF, then apply stall=6'b011111 for 3 cycles while ex_wdata changes -> mem_wdata stays 32'hDEAD_BEEF for all 3 cycles.
REQ-030 Flush beats stall: with stall=6'b011111 and flush=1 -> every output is 0 after the edge.
REQ-031 Async reset: pull rst low between clock edges while mem_we_reg=1 -> mem_we_reg=0 immediately, before the next edge.
REQ-032 Macro off: with EX_MEM_MADD_EN undefined, drive hilo_temp_i=64'hFFFF_FFFF_FFFF_FFFF and cnt_i=2'b11 under bubble -> hilo_temp_o=0 and cnt_o=0.
